// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath types and constants for the sequential multiplier
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int MUL_STEPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/twos_compliment.sv
// rtl/twos_compliment.sv - operand negation stage: invert-plus-one ripple chain
module twos_compliment #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Adding 1 to ~a: each stage is a full adder with b=0, so carry only survives through zeros of a.
    logic [WIDTH-1:0] c;

    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign y[i] = ~a[i] ^ c[i];
            if (i < WIDTH - 1) begin : g_carry
                assign c[i+1] = ~a[i] & c[i];
            end
        end
    endgenerate

endmodule

// File: rtl/twos_compliment16.sv
// rtl/twos_compliment16.sv - 16-bit invert-plus-one chain used to re-apply the product sign
module twos_compliment16 (
    input  logic [15:0] a,
    output logic [15:0] y
);

    logic [15:0] c;

    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_bit
            assign y[i] = ~a[i] ^ c[i];
            if (i < 15) begin : g_carry
                assign c[i+1] = ~a[i] & c[i];
            end
        end
    endgenerate

endmodule

// File: rtl/seq_signed_multiplier.sv
// rtl/seq_signed_multiplier.sv - 8x8 shift-and-add multiplier, signed operands when MUL_SIGNED_EN is defined
module seq_signed_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = $clog2(MUL_STEPS);

    mul_state_t           state, state_next;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH-1:0]     op_a, op_b;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   fix_val;
    logic [CW-1:0]        cnt;

`ifdef MUL_SIGNED_EN
    logic                 sign;
    logic [WIDTH-1:0]     neg_a, neg_b;
    logic [2*WIDTH-1:0]   neg_acc;

    twos_compliment #(.WIDTH(WIDTH)) u_neg_a (.a(A), .y(neg_a));
    twos_compliment #(.WIDTH(WIDTH)) u_neg_b (.a(B), .y(neg_b));
    twos_compliment16 u_neg_acc (.a(acc), .y(neg_acc));

    // 0x80 negates to itself, which read unsigned is the correct magnitude 128.
    assign op_a    = A[WIDTH-1] ? neg_a : A;
    assign op_b    = B[WIDTH-1] ? neg_b : B;
    assign fix_val = sign ? neg_acc : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sign <= A[WIDTH-1] ^ B[WIDTH-1];
        end
    end
`else
    assign op_a    = A;
    assign op_b    = B;
    assign fix_val = acc;
`endif

    assign addend = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        case (state)
            IDLE: if (in_valid)                     state_next = CALC;
            CALC: if (cnt == CW'(MUL_STEPS - 1))    state_next = FIX;
            FIX:                                    state_next = DONE;
            DONE: if (out_ready)                    state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mag_a <= '0;
            mag_b <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= op_a;
                        mag_b <= op_b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + addend;
                    cnt <= cnt + 1'b1;
                end
                FIX: P <= fix_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// tb/tb_seq_signed_multiplier.sv - randomized self-checking bench for seq_signed_multiplier
module tb_seq_signed_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A, B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;

    int total = 0;
    int bad   = 0;

    seq_signed_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int sa, sb, prod;
`ifdef MUL_SIGNED_EN
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        prod = sa * sb;
        return prod[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept, waits for the product, holds it for 'hold' cycles, then takes it.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                          output logic [15:0] p, output int lat);
        A = a;
        B = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        p = P;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        A = 8'h12;
        B = 8'h34;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (P !== 16'h0000) begin bad++; $display("FAIL reset_p got=%h want=0000", P); end
    endtask

    task automatic test_directed();
        logic [7:0]  da [5];
        logic [7:0]  db [5];
        logic [15:0] dp [5];
        logic [15:0] p;
        int lat;
`ifdef MUL_SIGNED_EN
        da = '{8'h03, 8'hFD, 8'h7F, 8'h80, 8'h00};
        db = '{8'h05, 8'h05, 8'h80, 8'h80, 8'hFB};
        dp = '{16'h000F, 16'hFFF1, 16'hC080, 16'h4000, 16'h0000};
`else
        da = '{8'h03, 8'hFF, 8'h7F, 8'h80, 8'h00};
        db = '{8'h05, 8'hFF, 8'h80, 8'h80, 8'hFB};
        dp = '{16'h000F, 16'hFE01, 16'h3F80, 16'h4000, 16'h0000};
`endif
        for (int i = 0; i < 5; i++) begin
            run_op(da[i], db[i], 0, p, lat);
            total++;
            if (p !== dp[i]) begin
                bad++;
                $display("FAIL directed_p a=%h b=%h got=%h want=%h", da[i], db[i], p, dp[i]);
            end
            total++;
            if (lat !== 9) begin bad++; $display("FAIL directed_latency a=%h b=%h got=%0d want=9", da[i], db[i], lat); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  a, b;
        logic [15:0] p, exp_p;
        int lat;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 8'h80;
                1: a = 8'h00;
                default: a = 8'($urandom);
            endcase
            b = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
            exp_p = model(a, b);
            repeat ($urandom_range(0, 2)) tick();
            run_op(a, b, $urandom_range(0, 3), p, lat);
            total++;
            if (p !== exp_p) begin bad++; $display("FAIL random_p a=%h b=%h got=%h want=%h", a, b, p, exp_p); end
            total++;
            if (lat !== 9) begin bad++; $display("FAIL random_latency got=%0d want=9", lat); end
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL random_after_take in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p0, p;
        int lat;
        A = 8'h0B;
        B = 8'h0D;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        p0 = P;
        total++;
        if (p0 !== model(8'h0B, 8'h0D)) begin bad++; $display("FAIL bp_p got=%h want=%h", p0, model(8'h0B, 8'h0D)); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            A = 8'($urandom);
            B = 8'($urandom);
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || P !== p0) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b in_ready=%b p=%h want 1/0/%h", i, out_valid, in_ready, P, p0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        run_op(8'h06, 8'h07, 0, p, lat);
        total++;
        if (p !== model(8'h06, 8'h07)) begin bad++; $display("FAIL bp_next_p got=%h want=%h", p, model(8'h06, 8'h07)); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        int seen;
        A = 8'h55;
        B = 8'h33;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 16'h0000) begin
            bad++;
            $display("FAIL reset_mid_state in_ready=%b out_valid=%b p=%h want 1/0/0000", in_ready, out_valid, P);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL reset_mid_stale_valid got=%0d want=0", seen); end
        run_op(8'h02, 8'h02, 0, p, lat);
        total++;
        if (p !== 16'h0004 || lat !== 9) begin
            bad++;
            $display("FAIL reset_mid_fresh p=%h lat=%0d want 0004/9", p, lat);
        end
        // reset while the product is being held in DONE
        A = 8'h7F;
        B = 8'h7F;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        total++;
        if (out_valid !== 1'b1 || P !== 16'h3F01) begin
            bad++;
            $display("FAIL reset_done_pre out_valid=%b p=%h want 1/3f01", out_valid, P);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 16'h0000) begin
            bad++;
            $display("FAIL reset_done_state in_ready=%b out_valid=%b p=%h want 1/0/0000", in_ready, out_valid, P);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  oa [4];
        logic [7:0]  ob [4];
        logic [15:0] expq [$];
        logic [15:0] e;
        int idx, got, cyc, last_acc;
        bit acc_now;
        for (int i = 0; i < 4; i++) begin
            oa[i] = 8'($urandom);
            ob[i] = 8'($urandom);
        end
        idx = 0;
        got = 0;
        cyc = 0;
        last_acc = -1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        A = oa[0];
        B = ob[0];
        while (got < 4 && cyc < 100) begin
            acc_now = in_ready && in_valid;
            tick();
            cyc++;
            if (acc_now) begin
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc !== 11) begin
                        bad++;
                        $display("FAIL b2b_spacing got=%0d want=11", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                expq.push_back(model(A, B));
                idx++;
                if (idx < 4) begin
                    A = oa[idx];
                    B = ob[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                total++;
                if (P !== e) begin bad++; $display("FAIL b2b_p idx=%0d got=%h want=%h", got, P, e); end
                got++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (got !== 4) begin bad++; $display("FAIL b2b_timeout results=%0d want=4", got); end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = 8'h00;
        B = 8'h00;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
